// File: rtl/regwrite_scheduler_pkg.sv
// Shared widths and grant encoding for the register-file write scheduler.
package regwrite_scheduler_pkg;

  localparam int DW       = 32;
  localparam int AW       = 4;
  localparam int NUM_REGS = 2 ** AW;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_MD   = 2'd2
  } gnt_e;

endpackage

// File: rtl/regwrite_scheduler_if.sv
// Bundle of the writeback, MulDiv, issue, operand-check and register-file write signals.
interface regwrite_scheduler_if import regwrite_scheduler_pkg::*; ();

  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_ready;

  logic          md_valid;
  logic [AW-1:0] md_rd;
  logic [DW-1:0] md_data;
  logic          md_ready;

  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;

  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic [AW-1:0] chk_rd;
  logic [2:0]    chk_en;
  logic          hazard_stall;

  logic [AW-1:0] reg_wr1;
  logic [DW-1:0] reg_wr1_data;
  logic          wr1_enable;

  // Pipeline / MulDiv / register-file side
  modport master (
    output wb_valid, wb_rd, wb_data,
    output md_valid, md_rd, md_data,
    output issue_valid, issue_rd,
    output chk_rs1, chk_rs2, chk_rd, chk_en,
    input  wb_ready, md_ready, issue_ready, hazard_stall,
    input  reg_wr1, reg_wr1_data, wr1_enable
  );

  // Scheduler side
  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  md_valid, md_rd, md_data,
    input  issue_valid, issue_rd,
    input  chk_rs1, chk_rs2, chk_rd, chk_en,
    output wb_ready, md_ready, issue_ready, hazard_stall,
    output reg_wr1, reg_wr1_data, wr1_enable
  );

endinterface

// File: rtl/regwrite_scheduler_scoreboard.sv
// Busy scoreboard for registers with an outstanding MulDiv result; gates issue and flags operand hazards.
module regwrite_scheduler_scoreboard import regwrite_scheduler_pkg::*; #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          issue_valid_i,
  input  logic [AW-1:0] issue_rd_i,
  output logic          issue_ready_o,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_rd_i,
  input  logic [AW-1:0] chk_rs1_i,
  input  logic [AW-1:0] chk_rs2_i,
  input  logic [AW-1:0] chk_rd_i,
  input  logic [2:0]    chk_en_i,
  output logic          hazard_stall_o
);

  localparam int             CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic                set_en;
  logic                clr_hit;

  // Issue permission and hazard lookup from the current-cycle busy bits (no same-cycle bypass)
  always_comb begin
    issue_ready_o  = !reset && !busy_q[issue_rd_i] && (out_cnt_q < CNT_MAX);
    set_en         = issue_valid_i && issue_ready_o;
    // Only count a clear that actually retires a busy bit, keeping out_cnt == popcount(busy)
    clr_hit        = clr_en_i && busy_q[clr_rd_i];
    hazard_stall_o = !reset && ((chk_en_i[0] && busy_q[chk_rs1_i]) ||
                                (chk_en_i[1] && busy_q[chk_rs2_i]) ||
                                (chk_en_i[2] && busy_q[chk_rd_i]));
  end

  // Next busy vector and outstanding count; a set and a clear never hit the same register
  always_comb begin
    busy_d    = busy_q;
    out_cnt_d = out_cnt_q;
    if (clr_hit) busy_d[clr_rd_i]   = 1'b0;
    if (set_en)  busy_d[issue_rd_i] = 1'b1;
    case ({set_en, clr_hit})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Scoreboard state
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= '0;
      out_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: rtl/regwrite_scheduler.sv
// Shares the register-file write port between pipeline writeback and a one-entry MulDiv hold buffer,
// with a bounded-starvation priority so a held MulDiv result cannot lose to writeback forever.
module regwrite_scheduler import regwrite_scheduler_pkg::*; #(
  parameter int STARVE_LIMIT    = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                 clock,
  input logic                 reset,
  regwrite_scheduler_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic          hold_v_q, hold_v_d;
  logic [AW-1:0] hold_rd_q, hold_rd_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [3:0]    starve_q, starve_d;
  logic          force_hold;
  logic          md_take;
  gnt_e          gnt;

  // Arbitration: a starved hold entry beats writeback, otherwise writeback has priority
  always_comb begin
    force_hold = hold_v_q && (starve_q == STARVE_MAX);
    gnt        = GNT_NONE;
    if (reset)              gnt = GNT_NONE;
    else if (force_hold)    gnt = GNT_MD;
    else if (bus.wb_valid)  gnt = GNT_WB;
    else if (hold_v_q)      gnt = GNT_MD;
    bus.wb_ready = !reset && !force_hold;
    bus.md_ready = !reset && !hold_v_q;
    md_take      = bus.md_valid && bus.md_ready;
  end

  // Register-file write port driven by the winner in the same cycle
  always_comb begin
    bus.wr1_enable   = 1'b0;
    bus.reg_wr1      = '0;
    bus.reg_wr1_data = '0;
    case (gnt)
      GNT_WB: begin
        bus.wr1_enable   = 1'b1;
        bus.reg_wr1      = bus.wb_rd;
        bus.reg_wr1_data = bus.wb_data;
      end
      GNT_MD: begin
        bus.wr1_enable   = 1'b1;
        bus.reg_wr1      = hold_rd_q;
        bus.reg_wr1_data = hold_data_q;
      end
      default: ;
    endcase
  end

  // Hold buffer and starvation counter next state
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    starve_d    = starve_q;
    if (gnt == GNT_MD) hold_v_d = 1'b0;
    if (md_take) begin
      hold_v_d    = 1'b1;
      hold_rd_d   = bus.md_rd;
      hold_data_d = bus.md_data;
    end
    if (!hold_v_q || gnt == GNT_MD)
      starve_d = '0;
    else if (gnt == GNT_WB && starve_q != STARVE_MAX)
      starve_d = starve_q + 4'd1;
  end

  // Control state is reset; the held address/data only matter while hold_v is set
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_v_q <= 1'b0;
      starve_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      starve_q <= starve_d;
    end
    hold_rd_q   <= hold_rd_d;
    hold_data_q <= hold_data_d;
  end

  regwrite_scheduler_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .issue_valid_i (bus.issue_valid),
    .issue_rd_i    (bus.issue_rd),
    .issue_ready_o (bus.issue_ready),
    .clr_en_i      (gnt == GNT_MD),
    .clr_rd_i      (hold_rd_q),
    .chk_rs1_i     (bus.chk_rs1),
    .chk_rs2_i     (bus.chk_rs2),
    .chk_rd_i      (bus.chk_rd),
    .chk_en_i      (bus.chk_en),
    .hazard_stall_o(bus.hazard_stall)
  );

endmodule

// File: tb/tb_regwrite_scheduler.sv
// Directed and randomized bench for regwrite_scheduler against a behavioural reference model.
module tb_regwrite_scheduler;
  import regwrite_scheduler_pkg::*;

  localparam int STARVE_LIMIT = 3;
  localparam int MAX_OUT      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regwrite_scheduler_if bus();

  regwrite_scheduler #(
    .STARVE_LIMIT   (STARVE_LIMIT),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the held result, how many times in a row it has lost, and the set of busy registers
  bit            m_hold_v   = 0;
  int            m_hold_rd  = 0;
  logic [DW-1:0] m_hold_data = '0;
  int            m_losses   = 0;
  bit            m_busy [NUM_REGS];
  int            pend [$];
  bit            md_acc_last = 0;
  bit            prev_rst    = 1;

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < NUM_REGS; i++) n += m_busy[i];
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.md_valid = 0; bus.md_rd = '0; bus.md_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0; bus.chk_en = '0;
  endtask

  // Compare every output with the model, then advance the model across the coming edge
  task automatic model_step();
    bit exp_force, exp_issue, exp_haz;
    int win;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    exp_force = m_hold_v && (m_losses >= STARVE_LIMIT);
    if (rst)               win = 0;
    else if (exp_force)    win = 2;
    else if (bus.wb_valid) win = 1;
    else if (m_hold_v)     win = 2;
    else                   win = 0;
    exp_issue = !rst && !m_busy[bus.issue_rd] && (busy_count() < MAX_OUT);
    exp_haz   = !rst && ((bus.chk_en[0] && m_busy[bus.chk_rs1]) ||
                         (bus.chk_en[1] && m_busy[bus.chk_rs2]) ||
                         (bus.chk_en[2] && m_busy[bus.chk_rd]));
    exp_addr  = (win == 1) ? bus.wb_rd   : (win == 2) ? AW'(m_hold_rd) : '0;
    exp_data  = (win == 1) ? bus.wb_data : (win == 2) ? m_hold_data    : '0;
    chk("wb_ready",     bus.wb_ready,     !rst && !exp_force);
    chk("md_ready",     bus.md_ready,     !rst && !m_hold_v);
    chk("issue_ready",  bus.issue_ready,  exp_issue);
    chk("hazard_stall", bus.hazard_stall, exp_haz);
    chk("wr1_enable",   bus.wr1_enable,   win != 0);
    chk("reg_wr1",      bus.reg_wr1,      exp_addr);
    chk("reg_wr1_data", bus.reg_wr1_data, exp_data);
    if (rst) begin
      m_hold_v = 0; m_losses = 0; md_acc_last = 0;
      for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
      pend.delete();
    end else begin
      md_acc_last = bus.md_valid && !m_hold_v;
      if (win == 2) begin
        m_busy[m_hold_rd] = 0;
        m_hold_v = 0;
        m_losses = 0;
      end else if (win == 1 && m_hold_v) begin
        m_losses = (m_losses + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_losses + 1;
      end else begin
        m_losses = 0;
      end
      if (exp_issue && bus.issue_valid) begin
        m_busy[bus.issue_rd] = 1;
        pend.push_back(int'(bus.issue_rd));
      end
      if (md_acc_last) begin
        m_hold_v = 1; m_hold_rd = int'(bus.md_rd); m_hold_data = bus.md_data;
        if (pend.size() > 0) void'(pend.pop_front());
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic rest();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    rest();
  endtask

  task automatic issue(input int rd);
    idle();
    bus.issue_valid = 1; bus.issue_rd = AW'(rd);
    half(); chk("issue_accept", bus.issue_ready, 1); rest();
    bus.issue_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 0;
    idle();
    // Reset with both requesters active
    rst = 1; bus.wb_valid = 1; bus.md_valid = 1; bus.md_rd = 4; bus.md_data = 32'hDEAD;
    @(posedge clk); #1;
    half();
    chk("rst_wr1_enable", bus.wr1_enable, 0);
    chk("rst_wb_ready",   bus.wb_ready,   0);
    chk("rst_md_ready",   bus.md_ready,   0);
    rest();

    // Writeback passes straight through
    rst = 0; idle(); bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hA5;
    half();
    chk("wb_en", bus.wr1_enable, 1); chk("wb_addr", bus.reg_wr1, 5); chk("wb_data", bus.reg_wr1_data, 32'hA5);
    rest();

    // MulDiv result buffered then written next cycle
    issue(3);
    idle(); bus.md_valid = 1; bus.md_rd = 3; bus.md_data = 32'h1234;
    half(); chk("md_load_ready", bus.md_ready, 1); chk("md_load_noen", bus.wr1_enable, 0); rest();
    idle();
    half();
    chk("md_wr_en", bus.wr1_enable, 1); chk("md_wr_addr", bus.reg_wr1, 3);
    chk("md_wr_data", bus.reg_wr1_data, 32'h1234); chk("md_wr_ready", bus.md_ready, 0);
    rest();
    half(); chk("md_ready_back", bus.md_ready, 1); chk("md_idle_noen", bus.wr1_enable, 0); rest();

    // Starvation bound with continuous writeback
    issue(9);
    idle(); bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h11;
    bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 32'h99;
    half(); chk("starve_load_wb", bus.reg_wr1, 1); rest();
    bus.md_valid = 0;
    for (int k = 0; k < 3; k++) begin
      half(); chk("starve_wb_ready", bus.wb_ready, 1); chk("starve_wb_addr", bus.reg_wr1, 1); rest();
    end
    half();
    chk("starve_force_ready", bus.wb_ready, 0); chk("starve_force_addr", bus.reg_wr1, 9);
    chk("starve_force_data", bus.reg_wr1_data, 32'h99);
    rest();
    half(); chk("starve_resume_ready", bus.wb_ready, 1); chk("starve_resume_addr", bus.reg_wr1, 1); rest();

    // Hazard on a busy source until its write lands
    issue(7);
    idle(); bus.chk_rs1 = 7; bus.chk_en = 3'b001;
    half(); chk("haz_busy", bus.hazard_stall, 1); rest();
    bus.md_valid = 1; bus.md_rd = 7; bus.md_data = 32'h77;
    half(); chk("haz_held", bus.hazard_stall, 1); rest();
    bus.md_valid = 0;
    half(); chk("haz_on_write", bus.hazard_stall, 1); chk("haz_write_addr", bus.reg_wr1, 7); rest();
    half(); chk("haz_cleared", bus.hazard_stall, 0); rest();

    // Issue limits: busy register and outstanding cap
    issue(2);
    bus.issue_valid = 1; bus.issue_rd = 2;
    half(); chk("issue_busy_block", bus.issue_ready, 0); rest();
    issue(10); issue(11); issue(12);
    bus.issue_valid = 1; bus.issue_rd = 13;
    half(); chk("issue_cap_block", bus.issue_ready, 0); rest();
    idle(); bus.md_valid = 1; bus.md_rd = 2; bus.md_data = 32'h22; tick();
    idle(); tick();
    bus.issue_valid = 1; bus.issue_rd = 13;
    half(); chk("issue_cap_free", bus.issue_ready, 1); rest();

    // Reset while holding a result with busy = {r0, r7}
    idle(); rst = 1; tick(); rst = 0;
    issue(0); issue(7);
    idle(); bus.wb_valid = 1; bus.wb_rd = 1; bus.md_valid = 1; bus.md_rd = 0; bus.md_data = 32'h5;
    tick();
    rst = 1; bus.md_valid = 0;
    half(); chk("midrst_noen", bus.wr1_enable, 0); rest();
    rst = 0; idle(); bus.issue_rd = 7; bus.chk_rs1 = 0; bus.chk_rs2 = 7; bus.chk_rd = 7; bus.chk_en = 3'b111;
    half();
    chk("midrst_md_ready", bus.md_ready, 1); chk("midrst_noen2", bus.wr1_enable, 0);
    chk("midrst_issue7", bus.issue_ready, 1); chk("midrst_haz", bus.hazard_stall, 0);
    rest();
    bus.issue_rd = 0;
    half(); chk("midrst_issue0", bus.issue_ready, 1); rest();

    // Randomized traffic against the model
    idle(); rst = 1; tick(); prev_rst = 1;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.wb_valid = 1'($urandom_range(0, 1));
      bus.wb_rd    = AW'($urandom_range(0, NUM_REGS - 1));
      bus.wb_data  = $urandom;
      if (prev_rst || !(bus.md_valid && !md_acc_last)) begin
        if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
          bus.md_valid = 1; bus.md_rd = AW'(pend[0]); bus.md_data = $urandom;
        end else begin
          bus.md_valid = 0;
        end
      end
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = AW'($urandom_range(0, NUM_REGS - 1));
      bus.chk_rs1 = AW'($urandom_range(0, NUM_REGS - 1));
      bus.chk_rs2 = AW'($urandom_range(0, NUM_REGS - 1));
      bus.chk_rd  = AW'($urandom_range(0, NUM_REGS - 1));
      bus.chk_en  = 3'($urandom_range(0, 7));
      tick();
      prev_rst = rst;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
